// File: rtl/store_dispatch_pkg.sv
// store_dispatch_pkg: shared store-path constants, uop encoding and buffer entry type
package store_dispatch_pkg;
  localparam logic [4:0] UOP_STR = 5'h0D;
  localparam logic [31:0] DCACHE_LIMIT = 32'd31;
  localparam logic [31:0] GPIO_ADDR = 32'd31;
  typedef struct packed {
    logic [4:0] addr;
    logic [31:0] data;
  } store_entry_t;
endpackage

// File: rtl/store_dispatch_if.sv
// store_dispatch_if: execute-side store inputs, D-cache write handshake and GPIO outputs
interface store_dispatch_if #(parameter int GPIO_WIDTH = 32);
  logic [4:0] uop;
  logic [31:0] addr;
  logic [31:0] data;
  logic stall;
  logic dc_wr_valid;
  logic [4:0] dc_wr_addr;
  logic [31:0] dc_wr_data;
  logic dc_wr_ready;
  logic [GPIO_WIDTH-1:0] gpio_out;
  logic gpio_we;
  logic err_unmapped;
  modport slave (
    input uop, addr, data, dc_wr_ready,
    output stall, dc_wr_valid, dc_wr_addr, dc_wr_data, gpio_out, gpio_we, err_unmapped
  );
  modport master (
    output uop, addr, data, dc_wr_ready,
    input stall, dc_wr_valid, dc_wr_addr, dc_wr_data, gpio_out, gpio_we, err_unmapped
  );
endinterface

// File: rtl/store_dispatch_fifo.sv
// store_fifo: in-order write buffer with valid/ready pop and occupancy count
module store_fifo
  import store_dispatch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  store_entry_t din,
  input  logic pop_ready,
  output logic valid,
  output store_entry_t dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  store_entry_t mem_q [DEPTH];
  store_entry_t mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  always_comb begin
    do_push = push && count_q != CW'(DEPTH);
    do_pop = count_q != '0 && pop_ready;
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = din;
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  assign valid = count_q != '0;
  assign dout = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/store_dispatch.sv
// store_dispatch: decodes STR micro-ops into buffered D-cache writes, GPIO writes or error pulses
module store_dispatch
  import store_dispatch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int GPIO_WIDTH = 32
) (
  input logic clk,
  input logic rst_n,
  store_dispatch_if.slave bus
);
  localparam int CW = $clog2(DEPTH+1);
  logic accept, push;
  logic [CW-1:0] count;
  store_entry_t entry, head;
  logic [GPIO_WIDTH-1:0] gpio_out_q, gpio_out_d;
  logic gpio_we_q, gpio_we_d, err_q, err_d;
  always_comb begin
    accept = bus.uop == UOP_STR && !bus.stall;
    push = accept && bus.addr < DCACHE_LIMIT;
    gpio_we_d = accept && bus.addr == GPIO_ADDR;
    err_d = accept && bus.addr > GPIO_ADDR;
    gpio_out_d = gpio_we_d ? bus.data[GPIO_WIDTH-1:0] : gpio_out_q;
    entry = '{addr: bus.addr[4:0], data: bus.data};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gpio_out_q <= '0;
      gpio_we_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      gpio_out_q <= gpio_out_d;
      gpio_we_q <= gpio_we_d;
      err_q <= err_d;
    end
  end
  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .din(entry),
    .pop_ready(bus.dc_wr_ready),
    .valid(bus.dc_wr_valid),
    .dout(head),
    .count(count)
  );
  // stall comes from the registered count so a pop while full only frees a slot next cycle
  assign bus.stall = count == CW'(DEPTH);
  assign bus.dc_wr_addr = head.addr;
  assign bus.dc_wr_data = head.data;
  assign bus.gpio_out = gpio_out_q;
  assign bus.gpio_we = gpio_we_q;
  assign bus.err_unmapped = err_q;
endmodule

// File: tb/tb_store_dispatch.sv
// tb_store_dispatch: table-driven directed check of store decode, write buffer and reset
module tb_store_dispatch;
  import store_dispatch_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0;
  int n_err = 0;
  store_dispatch_if #(.GPIO_WIDTH(32)) bus ();
  store_dispatch #(.DEPTH(2), .GPIO_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic rst_n;
    logic [4:0] uop;
    logic [31:0] addr;
    logic [31:0] data;
    logic rdy;
    logic stall;
    logic vld;
    logic [4:0] waddr;
    logic [31:0] wdata;
    logic [31:0] gpio;
    logic gwe;
    logic err;
  } vec_t;
  vec_t v[$];

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [4:0] u, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    rst_n = r;
    bus.uop = u;
    bus.addr = a;
    bus.data = d;
    bus.dc_wr_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  localparam logic [4:0] NOP = 5'h00;
  localparam logic [4:0] OTH = 5'h01;

  initial begin
    // rst, uop, addr, data, rdy | stall, vld, waddr, wdata, gpio, gwe, err
    v.push_back('{0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    v.push_back('{0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    v.push_back('{1, UOP_STR, 5, 32'hDEADBEEF, 1, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0});
    v.push_back('{1, NOP, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0});
    v.push_back('{1, UOP_STR, 31, 32'h000000A5, 1, 0, 0, 0, 0, 32'hA5, 1, 0});
    v.push_back('{1, NOP, 0, 0, 1, 0, 0, 0, 0, 32'hA5, 0, 0});
    v.push_back('{1, UOP_STR, 1, 32'h11, 0, 0, 1, 1, 32'h11, 32'hA5, 0, 0});
    v.push_back('{1, UOP_STR, 2, 32'h22, 0, 1, 1, 1, 32'h11, 32'hA5, 0, 0});
    v.push_back('{1, UOP_STR, 3, 32'h33, 0, 1, 1, 1, 32'h11, 32'hA5, 0, 0});
    v.push_back('{1, UOP_STR, 3, 32'h33, 0, 1, 1, 1, 32'h11, 32'hA5, 0, 0});
    v.push_back('{1, UOP_STR, 3, 32'h33, 1, 0, 1, 2, 32'h22, 32'hA5, 0, 0});
    v.push_back('{1, UOP_STR, 3, 32'h33, 1, 0, 1, 3, 32'h33, 32'hA5, 0, 0});
    v.push_back('{1, NOP, 0, 0, 1, 0, 0, 0, 0, 32'hA5, 0, 0});
    v.push_back('{1, UOP_STR, 40, 32'h12345678, 1, 0, 0, 0, 0, 32'hA5, 0, 1});
    v.push_back('{1, NOP, 0, 0, 1, 0, 0, 0, 0, 32'hA5, 0, 0});
    v.push_back('{1, UOP_STR, 6, 32'h66, 0, 0, 1, 6, 32'h66, 32'hA5, 0, 0});
    v.push_back('{1, UOP_STR, 7, 32'h77, 1, 0, 1, 7, 32'h77, 32'hA5, 0, 0});
    v.push_back('{1, NOP, 0, 0, 0, 0, 1, 7, 32'h77, 32'hA5, 0, 0});
    v.push_back('{1, NOP, 0, 0, 1, 0, 0, 0, 0, 32'hA5, 0, 0});
    v.push_back('{1, UOP_STR, 8, 32'h88, 0, 0, 1, 8, 32'h88, 32'hA5, 0, 0});
    v.push_back('{1, UOP_STR, 9, 32'h99, 0, 1, 1, 8, 32'h88, 32'hA5, 0, 0});
    v.push_back('{0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    v.push_back('{1, UOP_STR, 10, 32'hAA, 0, 0, 1, 10, 32'hAA, 0, 0, 0});
    v.push_back('{1, NOP, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0});
    v.push_back('{1, UOP_STR, 30, 32'h30, 1, 0, 1, 30, 32'h30, 0, 0, 0});
    v.push_back('{1, UOP_STR, 32, 32'h32, 1, 0, 0, 0, 0, 0, 0, 1});
    v.push_back('{1, OTH, 31, 32'hFF, 1, 0, 0, 0, 0, 0, 0, 0});
    v.push_back('{1, UOP_STR, 31, 32'h1, 1, 0, 0, 0, 0, 32'h1, 1, 0});
    v.push_back('{1, UOP_STR, 31, 32'h2, 1, 0, 0, 0, 0, 32'h2, 1, 0});
    v.push_back('{1, NOP, 0, 0, 1, 0, 0, 0, 0, 32'h2, 0, 0});
    foreach (v[i]) begin
      step(v[i].rst_n, v[i].uop, v[i].addr, v[i].data, v[i].rdy);
      check("stall", i, 32'(bus.stall), 32'(v[i].stall));
      check("dc_wr_valid", i, 32'(bus.dc_wr_valid), 32'(v[i].vld));
      if (v[i].vld) begin
        check("dc_wr_addr", i, 32'(bus.dc_wr_addr), 32'(v[i].waddr));
        check("dc_wr_data", i, bus.dc_wr_data, v[i].wdata);
      end
      check("gpio_out", i, bus.gpio_out, v[i].gpio);
      check("gpio_we", i, 32'(bus.gpio_we), 32'(v[i].gwe));
      check("err_unmapped", i, 32'(bus.err_unmapped), 32'(v[i].err));
    end
    // full buffer held under backpressure: head stays put, then drains in order
    step(1, UOP_STR, 20, 32'hA020, 0);
    step(1, UOP_STR, 21, 32'hA021, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, UOP_STR, 22, 32'hA022, 0);
      check("hold_stall", 100 + k, 32'(bus.stall), 32'd1);
      check("hold_addr", 100 + k, 32'(bus.dc_wr_addr), 32'd20);
      check("hold_data", 100 + k, bus.dc_wr_data, 32'hA020);
    end
    step(1, NOP, 0, 0, 1);
    check("drain1_addr", 110, 32'(bus.dc_wr_addr), 32'd21);
    check("drain1_data", 110, bus.dc_wr_data, 32'hA021);
    check("drain1_stall", 110, 32'(bus.stall), 32'd0);
    step(1, NOP, 0, 0, 1);
    check("drain2_valid", 111, 32'(bus.dc_wr_valid), 32'd0);
    // a store blocked by stall must not leak into GPIO either
    step(1, UOP_STR, 23, 32'h23, 0);
    step(1, UOP_STR, 24, 32'h24, 0);
    step(1, UOP_STR, 31, 32'h5A5A, 0);
    check("stalled_gpio_we", 120, 32'(bus.gpio_we), 32'd0);
    check("stalled_gpio", 120, bus.gpio_out, 32'h2);
    check("stalled_head", 120, 32'(bus.dc_wr_addr), 32'd23);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
